adder_operand_gen: RTL and testbench

Upstream stimulus stage for the 16-bit registered adder. Produces a bounded stream of operand pairs (a, b) from two Galois LFSRs over a valid/ready handshake. Also produces the golden 17-bit sum, delayed to line up with the adder's one-cycle registered output. Synthesizable, so the same vector source serves simulation and on-fabric self-test.

---
 rtl/adder_opgen_pkg.sv | 21 ++
 rtl/adder_operand_gen_lfsr.sv | 27 ++
 rtl/adder_operand_gen.sv | 127 ++++++++++++
 tb/tb_adder_operand_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_opgen_pkg.sv
// Shared types and constants for the adder operand generator: FSM states,
// default LFSR taps/seeds and the corner-vector table.
package adder_opgen_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0] DEF_TAPS   = 16'hB400;
    localparam logic [15:0] DEF_SEED_A = 16'hACE1;
    localparam logic [15:0] DEF_SEED_B = 16'h1D2B;

    // Corner words are encoded as codes so the table stays width-independent.
    localparam int N_CORNERS = 4;
    localparam logic [1:0] CW_ZERO = 2'd0;
    localparam logic [1:0] CW_ONES = 2'd1;
    localparam logic [1:0] CW_ONE  = 2'd2;
    localparam logic [1:0] CW_MSB  = 2'd3;

    localparam logic [N_CORNERS-1:0][1:0] CORNER_A = {CW_MSB, CW_ONES, CW_ONES, CW_ZERO};
    localparam logic [N_CORNERS-1:0][1:0] CORNER_B = {CW_MSB, CW_ONES, CW_ONE,  CW_ZERO};

endpackage

// File: rtl/adder_operand_gen_lfsr.sv
// Galois LFSR with synchronous seed (re)load; an all-zero seed is forced to 1
// so the register can never lock up.
module galois_lfsr
    import adder_opgen_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED_A)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= SEED_NZ;
        end else if (step) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/adder_operand_gen.sv
// Bounded operand-pair source for the registered adder, with a golden sum aligned
// to the adder's one-cycle latency. Macro ADDER_OPGEN_CORNER_EN prepends corner pairs.
module adder_operand_gen
    import adder_opgen_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               NUM_VECTORS = 20,
    parameter logic [WIDTH-1:0] LFSR_TAPS   = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED_A      = WIDTH'(DEF_SEED_A),
    parameter logic [WIDTH-1:0] SEED_B      = WIDTH'(DEF_SEED_B)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               ready_i,
    output logic                               valid_o,
    output logic [WIDTH-1:0]                   a_o,
    output logic [WIDTH-1:0]                   b_o,
    output logic [WIDTH:0]                     expected_o,
    output logic                               exp_valid_o,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   count_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int CNT_W = $clog2(NUM_VECTORS+1);
`ifdef ADDER_OPGEN_CORNER_EN
    localparam bit CORNER_EN = 1'b1;
`else
    localparam bit CORNER_EN = 1'b0;
`endif

    state_t             state_p0;
    logic [CNT_W-1:0]   count_p0;
    logic [WIDTH:0]     expected_p1;
    logic               vld_p1;
    logic [WIDTH-1:0]   lfsr_a;
    logic [WIDTH-1:0]   lfsr_b;
    logic [1:0]         corner_idx;
    logic               corner_act;
    logic               accept;
    logic               load;
    logic               step;

    function automatic logic [WIDTH-1:0] corner_word(input logic [1:0] code);
        case (code)
            CW_ZERO: corner_word = '0;
            CW_ONES: corner_word = '1;
            CW_ONE:  corner_word = WIDTH'(1);
            default: corner_word = {1'b1, {(WIDTH-1){1'b0}}};
        endcase
    endfunction

    function automatic logic [WIDTH:0] full_sum(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        full_sum = {1'b0, a} + {1'b0, b};
    endfunction

    assign corner_idx = 2'(count_p0);
    assign corner_act = CORNER_EN && (int'(count_p0) < N_CORNERS);

    assign valid_o = (state_p0 == RUN);
    assign busy_o  = (state_p0 == RUN) || (state_p0 == DRAIN);
    assign done_o  = (state_p0 == DONE);
    assign count_o = count_p0;

    // Operands come straight from registers, so nothing here depends on ready_i.
    assign a_o = (valid_o && corner_act) ? corner_word(CORNER_A[corner_idx]) : lfsr_a;
    assign b_o = (valid_o && corner_act) ? corner_word(CORNER_B[corner_idx]) : lfsr_b;

    assign accept = valid_o && ready_i;
    assign load   = start && ((state_p0 == IDLE) || (state_p0 == DONE));
    assign step   = accept && !corner_act;

    galois_lfsr #(.WIDTH(WIDTH), .TAPS(LFSR_TAPS), .SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .state (lfsr_a)
    );

    galois_lfsr #(.WIDTH(WIDTH), .TAPS(LFSR_TAPS), .SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .state (lfsr_b)
    );

    // p0 -> p1: golden sum registered alongside the adder's own output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0    <= IDLE;
            count_p0    <= '0;
            vld_p1      <= 1'b0;
            expected_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                expected_p1 <= full_sum(a_o, b_o);
            end
            case (state_p0)
                IDLE, DONE: begin
                    if (start) begin
                        state_p0 <= RUN;
                        count_p0 <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        count_p0 <= count_p0 + CNT_W'(1);
                        if (count_p0 == CNT_W'(NUM_VECTORS - 1)) begin
                            state_p0 <= DRAIN;
                        end
                    end
                end
                DRAIN:   state_p0 <= DONE;
                default: state_p0 <= IDLE;
            endcase
        end
    end

    assign expected_o  = expected_p1;
    assign exp_valid_o = vld_p1;

endmodule

// File: tb/tb_adder_operand_gen.sv
// Scoreboard bench for adder_operand_gen: a reference stream queued at each start,
// popped by a negedge monitor on every accept and every golden-sum cycle.
`timescale 1ns/1ps
module tb_adder_operand_gen;

    localparam int          WIDTH  = 16;
    localparam int          NUM    = 20;
    localparam int          CNT_W  = $clog2(NUM+1);
    localparam logic [15:0] TAPS   = 16'hB400;
    localparam logic [15:0] SEED_A = 16'hACE1;
    localparam logic [15:0] SEED_B = 16'h1D2B;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             ready_i;
    logic             valid_o;
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic [WIDTH:0]   expected_o;
    logic             exp_valid_o;
    logic [CNT_W-1:0] count_o;
    logic             busy_o;
    logic             done_o;

    pair_t       pairs_q[$];
    logic [16:0] sums_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    adder_operand_gen #(
        .WIDTH(WIDTH), .NUM_VECTORS(NUM), .LFSR_TAPS(TAPS),
        .SEED_A(SEED_A), .SEED_B(SEED_B)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ready_i(ready_i),
        .valid_o(valid_o), .a_o(a_o), .b_o(b_o), .expected_o(expected_o),
        .exp_valid_o(exp_valid_o), .count_o(count_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing", name);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    function automatic pair_t corner_pair(input int k);
        case (k)
            0:       return '{16'h0000, 16'h0000};
            1:       return '{16'hFFFF, 16'h0001};
            2:       return '{16'hFFFF, 16'hFFFF};
            default: return '{16'h8000, 16'h8000};
        endcase
    endfunction

    // Reference stream for one complete run, pushed when a start is honoured.
    task automatic push_run();
        logic [15:0] a = SEED_A;
        logic [15:0] b = SEED_B;
        pair_t       p;
        bit          use_corner;
        for (int k = 0; k < NUM; k++) begin
            use_corner = 1'b0;
`ifdef ADDER_OPGEN_CORNER_EN
            use_corner = (k < 4);
`endif
            if (use_corner) begin
                p = corner_pair(k);
            end else begin
                p.a = a;
                p.b = b;
                a = lfsr_next(a);
                b = lfsr_next(b);
            end
            pairs_q.push_back(p);
            sums_q.push_back({1'b0, p.a} + {1'b0, p.b});
        end
    endtask

    // Monitor
    logic             prev_acc = 1'b0;
    logic             prev_stall = 1'b0;
    logic [15:0]      sa, sb;
    logic [CNT_W-1:0] sc;

    always @(negedge clk) begin
        pair_t p;
        logic  acc;
        if (mon_en) begin
            check("exp_valid", 32'(exp_valid_o), 32'(prev_acc));
            if (exp_valid_o) begin
                if (sums_q.size() == 0) fail_now("expected_underflow");
                else check("expected_sum", 32'(expected_o), 32'(sums_q.pop_front()));
            end
            if (prev_stall && valid_o) begin
                check("stall_a", 32'(a_o), 32'(sa));
                check("stall_b", 32'(b_o), 32'(sb));
                check("stall_count", 32'(count_o), 32'(sc));
            end
            acc = valid_o && ready_i && !rst;
            if (acc) begin
                if (pairs_q.size() == 0) begin
                    fail_now("pair_underflow");
                end else begin
                    check("accept_count", 32'(count_o), 32'(NUM - pairs_q.size()));
                    p = pairs_q.pop_front();
                    check("pair_a", 32'(a_o), 32'(p.a));
                    check("pair_b", 32'(b_o), 32'(p.b));
                end
            end
            if (rst) begin
                pairs_q.delete();
                sums_q.delete();
            end
            prev_acc   = acc;
            prev_stall = valid_o && !ready_i && !rst;
            sa = a_o;
            sb = b_o;
            sc = count_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        tick();
        start   = 1'b1;
        ready_i = 1'b0;
        push_run();
        tick();
        start = 1'b0;
        @(negedge clk);
        #1;
        check("start_valid", 32'(valid_o), 32'd1);
        check("start_count", 32'(count_o), 32'd0);
        check("start_busy", 32'(busy_o), 32'd1);
        check("start_a", 32'(a_o), 32'(pairs_q[0].a));
        check("start_b", 32'(b_o), 32'(pairs_q[0].b));
`ifndef ADDER_OPGEN_CORNER_EN
        check("start_a_seed", 32'(a_o), 32'h0000ACE1);
        check("start_b_seed", 32'(b_o), 32'h00001D2B);
`endif
    endtask

    task automatic run_phase(input int stall_at, input int ign_at, input int rst_at);
        int n;
        int guard = 0;
        bit stalled = 1'b0;
        bit ignored = 1'b0;
        while (1) begin
            tick();
            start = 1'b0;
            if (pairs_q.size() == 0) break;
            if (++guard > 2000) begin
                fail_now("run_timeout");
                break;
            end
            n = NUM - pairs_q.size();
            if (n == rst_at) begin
                check("pre_reset_count", 32'(count_o), 32'(rst_at));
                rst = 1'b1;
                ready_i = 1'b0;
                tick();
                rst = 1'b0;
                @(negedge clk);
                #1;
                check("mid_reset_valid", 32'(valid_o), 32'd0);
                check("mid_reset_expv", 32'(exp_valid_o), 32'd0);
                check("mid_reset_count", 32'(count_o), 32'd0);
                check("mid_reset_busy", 32'(busy_o), 32'd0);
                check("mid_reset_done", 32'(done_o), 32'd0);
                break;
            end
            if (n == stall_at && !stalled) begin
                stalled = 1'b1;
                ready_i = 1'b0;
                repeat (4) begin
                    tick();
                    check("backpressure_count", 32'(count_o), 32'(stall_at));
                end
                continue;
            end
            if (n == ign_at && !ignored) begin
                ignored = 1'b1;
                start = 1'b1;
            end
            ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic done_checks();
        @(negedge clk);
        #1;
        check("drain_valid", 32'(valid_o), 32'd0);
        check("drain_busy", 32'(busy_o), 32'd1);
        check("drain_done", 32'(done_o), 32'd0);
        tick();
        check("done_flag", 32'(done_o), 32'd1);
        check("done_valid", 32'(valid_o), 32'd0);
        check("done_busy", 32'(busy_o), 32'd0);
        check("done_count", 32'(count_o), 32'(NUM));
        check("done_sums_left", 32'(sums_q.size()), 32'd0);
        repeat (3) tick();
        check("done_hold", 32'(done_o), 32'd1);
        check("done_count_hold", 32'(count_o), 32'(NUM));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ready_i = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        #1;
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_expv", 32'(exp_valid_o), 32'd0);
        check("reset_expected", 32'(expected_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_count", 32'(count_o), 32'd0);
        check("reset_a", 32'(a_o), 32'h0000ACE1);
        check("reset_b", 32'(b_o), 32'h00001D2B);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // Run 1: first accept by hand, then random ready with a stall and an ignored start
        start_run();
        tick();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
`ifndef ADDER_OPGEN_CORNER_EN
        check("second_a", 32'(a_o), 32'h0000E270);
        check("second_b", 32'(b_o), 32'h0000BA95);
        check("first_sum", 32'(expected_o), 32'h00000CA0C);
`endif
        check("first_sum_valid", 32'(exp_valid_o), 32'd1);
        check("first_count", 32'(count_o), 32'd1);
        run_phase(5, 10, -1);
        done_checks();

        // Run 2: restart from DONE, aborted by reset at count 7
        start_run();
        run_phase(-1, -1, 7);

        // Run 3: restart from IDLE, complete with an early stall
        start_run();
        run_phase(3, -1, -1);
        done_checks();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
